// File: rtl/read_pointer_empty.sv
// Read-side pointer/empty stage of the async FIFO: synchronises the write
// Gray pointer and tracks read pointers, empty, level and underflow.
module read_pointer_empty #(
    parameter int address_size        = 4,
    parameter int SYNC_STAGES         = 2,
    parameter int ALMOST_EMPTY_THRESH = 1
) (
    input  logic                    read_clk,
    input  logic                    read_reset,
    input  logic                    read_increment,
    input  logic                    underflow_clear,
    input  logic [address_size:0]   write_pointer_async,
    output logic [address_size-1:0] read_address,
    output logic [address_size:0]   read_pointer,
    output logic                    read_empty,
    output logic                    read_almost_empty,
    output logic [address_size:0]   read_level,
    output logic                    read_underflow
);

    localparam int PW = address_size + 1;
    localparam logic [PW-1:0] THRESH = PW'(ALMOST_EMPTY_THRESH);

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0] write_ptr_sync;
    logic [PW-1:0] write_bin_sync;

    logic [PW-1:0] read_binary_q;
    logic [PW-1:0] read_binary_d;
    logic [PW-1:0] read_gray_q;
    logic [PW-1:0] read_gray_d;
    logic [PW-1:0] level_q;
    logic [PW-1:0] level_d;
    logic          empty_q;
    logic          empty_d;
    logic          almost_empty_q;
    logic          almost_empty_d;
    logic          underflow_q;
    logic          underflow_d;
    logic          pop;

    // Plain flop chain: only the Gray-coded pointer crosses into read_clk.
    always_ff @(posedge read_clk or posedge read_reset) begin
        if (read_reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= write_pointer_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign write_ptr_sync = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        write_bin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            write_bin_sync[i] = ^(write_ptr_sync >> i);
        end
    end

    assign pop            = read_increment & ~empty_q;
    assign read_binary_d  = read_binary_q + PW'(pop);
    assign read_gray_d    = (read_binary_d >> 1) ^ read_binary_d;
    assign empty_d        = (read_gray_d == write_ptr_sync);
    assign level_d        = write_bin_sync - read_binary_d;
    assign almost_empty_d = (level_d <= THRESH);

    always_comb begin
        underflow_d = underflow_q;
        if (read_increment && empty_q) begin
            underflow_d = 1'b1;
        end else if (underflow_clear) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge read_clk or posedge read_reset) begin
        if (read_reset) begin
            read_binary_q  <= '0;
            read_gray_q    <= '0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            underflow_q    <= 1'b0;
        end else begin
            read_binary_q  <= read_binary_d;
            read_gray_q    <= read_gray_d;
            level_q        <= level_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            underflow_q    <= underflow_d;
        end
    end

    assign read_address      = read_binary_q[address_size-1:0];
    assign read_pointer      = read_gray_q;
    assign read_empty        = empty_q;
    assign read_almost_empty = almost_empty_q;
    assign read_level        = level_q;
    assign read_underflow    = underflow_q;

endmodule
